// File: rtl/hwextra_pkg.sv
// Shared constants and state encoding for the hwextra FIFO feeder.
package hwextra_pkg;

    // x^32 + x^22 + x^2 + x + 1, right-shift Galois form
    localparam logic [31:0] TAPS         = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr32_step.sv
// One step of the 32-bit right-shift Galois LFSR; purely combinational.
module lfsr32_step
    import hwextra_pkg::*;
(
    input  logic [31:0] lfsr,
    output logic [31:0] next
);

    assign next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);

endmodule

// File: rtl/hwextra_feeder.sv
// Bounded pseudo-random word source for the hwextra FIFO, honouring full/hold back-pressure.
module hwextra_feeder
    import hwextra_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] VAL_MASK = 32'h0000_03FF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      seed,
    input  logic             full,
    input  logic             hold,
    output logic [WIDTH-1:0] data,
    output logic             w_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_sent
);

    state_e           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [31:0]      lfsr_next;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [31:0]      masked;
    logic             push;

    lfsr32_step u_step (
        .lfsr (lfsr_q),
        .next (lfsr_next)
    );

    assign push   = (state_q == StRun) && !full && !hold;
    assign masked = lfsr_q & VAL_MASK;

    assign data       = masked[WIDTH-1:0];
    assign w_en       = push;
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign words_sent = sent_q;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        remaining_d = remaining_q;
        sent_d      = sent_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    sent_d = '0;
                    if (count != '0) begin
                        // A zero seed would lock the LFSR at zero forever
                        lfsr_d      = (seed == 32'h0) ? DEFAULT_SEED : seed;
                        remaining_d = count;
                        state_d     = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (push) begin
                    lfsr_d      = lfsr_next;
                    remaining_d = remaining_q - 1'b1;
                    sent_d      = sent_q + 1'b1;
                    if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            lfsr_q      <= '0;
            remaining_q <= '0;
            sent_q      <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            remaining_q <= remaining_d;
            sent_q      <= sent_d;
        end
    end

endmodule

// File: tb/tb_hwextra_feeder.sv
// Directed bench for hwextra_feeder with hand-computed LFSR words.
module tb_hwextra_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] count;
    logic [31:0] seed;
    logic        full;
    logic        hold;
    logic [31:0] data;
    logic        w_en;
    logic        busy;
    logic        done;
    logic [15:0] words_sent;

    int total = 0;
    int bad   = 0;

    hwextra_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .count      (count),
        .seed       (seed),
        .full       (full),
        .hold       (hold),
        .data       (data),
        .w_en       (w_en),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] s, input logic [15:0] n);
        seed  = s;
        count = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        count = '0;
        seed  = '0;
        full  = 1'b0;
        hold  = 1'b0;
        #1;
        check("rst_data", data, 32'h0);
        check("rst_wen", {31'h0, w_en}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_sent", {16'h0, words_sent}, 32'h0);
        step();
        step();
        reset = 1'b1;
        step();
        check("idle_wen", {31'h0, w_en}, 32'h0);

        // Basic run: seed=1, count=4
        go(32'h1, 16'd4);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_w0_wen", {31'h0, w_en}, 32'h1);
        check("t1_w0", data, 32'd1);
        step();
        check("t1_w1", data, 32'd3);
        check("t1_sent1", {16'h0, words_sent}, 32'd1);
        step();
        check("t1_w2", data, 32'd2);
        step();
        check("t1_w3_wen", {31'h0, w_en}, 32'h1);
        check("t1_w3", data, 32'd1);
        step();
        check("t1_done", {31'h0, done}, 32'h1);
        check("t1_busy_lo", {31'h0, busy}, 32'h0);
        check("t1_wen_lo", {31'h0, w_en}, 32'h0);
        check("t1_sent", {16'h0, words_sent}, 32'd4);

        // Stall after the 2nd push: full for 3 cycles, hold overlapping
        go(32'h1, 16'd4);
        check("t2_w0", data, 32'd1);
        step();
        check("t2_w1", data, 32'd3);
        step();
        full = 1'b1;
        #1;
        check("t2_s0_wen", {31'h0, w_en}, 32'h0);
        check("t2_s0_data", data, 32'd2);
        step();
        hold = 1'b1;
        #1;
        check("t2_s1_wen", {31'h0, w_en}, 32'h0);
        check("t2_s1_busy", {31'h0, busy}, 32'h1);
        step();
        hold = 1'b0;
        check("t2_s2_data", data, 32'd2);
        check("t2_s2_sent", {16'h0, words_sent}, 32'd2);
        step();
        full = 1'b0;
        #1;
        check("t2_w2_wen", {31'h0, w_en}, 32'h1);
        check("t2_w2", data, 32'd2);
        step();
        hold = 1'b1;
        #1;
        check("t2_hold_wen", {31'h0, w_en}, 32'h0);
        step();
        hold = 1'b0;
        check("t2_hold_data", data, 32'd1);
        #1;
        check("t2_w3", data, 32'd1);
        step();
        check("t2_done", {31'h0, done}, 32'h1);
        check("t2_sent", {16'h0, words_sent}, 32'd4);

        // Zero seed remaps to 1
        go(32'h0, 16'd2);
        check("t3_w0", data, 32'd1);
        step();
        check("t3_w1", data, 32'd3);
        step();
        check("t3_done", {31'h0, done}, 32'h1);
        check("t3_sent", {16'h0, words_sent}, 32'd2);

        // count=0 goes straight to DONE
        go(32'h1, 16'd0);
        check("t4_done", {31'h0, done}, 32'h1);
        check("t4_wen", {31'h0, w_en}, 32'h0);
        check("t4_sent", {16'h0, words_sent}, 32'd0);

        // Asynchronous reset mid-stream
        go(32'h1, 16'd10);
        step();
        step();
        check("t5_pre_sent", {16'h0, words_sent}, 32'd2);
        reset = 1'b0;
        #1;
        check("t5_data", data, 32'h0);
        check("t5_wen", {31'h0, w_en}, 32'h0);
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_done", {31'h0, done}, 32'h0);
        check("t5_sent", {16'h0, words_sent}, 32'd0);
        step();
        reset = 1'b1;
        step();
        go(32'h1, 16'd3);
        check("t5_w0", data, 32'd1);
        step();
        check("t5_w1", data, 32'd3);
        step();
        check("t5_w2", data, 32'd2);
        step();
        check("t5_done2", {31'h0, done}, 32'h1);
        check("t5_sent3", {16'h0, words_sent}, 32'd3);

        // Restart from DONE with start held high through the run
        seed  = 32'h1;
        count = 16'd2;
        start = 1'b1;
        step();
        check("t6_sent0", {16'h0, words_sent}, 32'd0);
        check("t6_w0", data, 32'd1);
        count = 16'd7;
        step();
        check("t6_w1", data, 32'd3);
        check("t6_sent1", {16'h0, words_sent}, 32'd1);
        step();
        start = 1'b0;
        check("t6_done", {31'h0, done}, 32'h1);
        check("t6_sent2", {16'h0, words_sent}, 32'd2);
        check("t6_wen", {31'h0, w_en}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
